// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the unified memory responder of the multi-cycle core.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REG_RAM    = 2'd0,
    REG_CYCLE  = 2'd1,
    REG_TOHOST = 2'd2,
    REG_NONE   = 2'd3
  } region_e;

  localparam logic [31:0] DEF_CYCLE_ADDR  = 32'hFFFF_FF00;
  localparam logic [31:0] DEF_TOHOST_ADDR = 32'hFFFF_FF04;

  // Byte-offset bits are ignored for the MMIO registers as well as for RAM.
  function automatic region_e decode_addr(input logic [31:0] adr,
                                          input logic [31:0] ram_bytes,
                                          input logic [31:0] cyc,
                                          input logic [31:0] toh);
    if (adr < ram_bytes)          return REG_RAM;
    if (adr[31:2] == cyc[31:2])   return REG_CYCLE;
    if (adr[31:2] == toh[31:2])   return REG_TOHOST;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/unified_ram.sv
// Instruction/data word RAM: one synchronous write port, one asynchronous read port.
module unified_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/multicycle_mem.sv
// Memory-side responder for the multi-cycle core: boot loader, RAM, cycle counter, tohost.
// state    | meaning
// S_LOAD   | boot stream fills RAM, core held in reset
// S_RUN    | core runs, counter counts
// S_HALTED | core wrote tohost; RAM and counter frozen until reset
module multicycle_mem
  import riscv_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] CYCLE_ADDR  = DEF_CYCLE_ADDR,
  parameter logic [31:0] TOHOST_ADDR = DEF_TOHOST_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Adr,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        core_rst_n,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        done,
  output logic [31:0] tohost,
  output logic        bad_access
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS) << 2;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH_WORDS - 1);

  state_e        state_q;
  logic [AW-1:0] load_ptr_q;
  logic [31:0]   cycle_q;
  logic [31:0]   tohost_q;
  logic          done_q;
  logic          bad_q;
  logic          ld_ready_q;
  logic          core_rst_n_q;

  region_e       region;
  logic [AW-1:0] word_idx;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  assign region   = decode_addr(Adr, RAM_BYTES, CYCLE_ADDR, TOHOST_ADDR);
  assign word_idx = Adr[AW+1:2];

  // Loader owns the write port in LOAD; the core only in RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = load_ptr_q;
    ram_wdata = ld_data;
    if (state_q == S_LOAD) begin
      ram_we = ld_valid;
    end else if (state_q == S_RUN && MemWrite && region == REG_RAM) begin
      ram_we    = 1'b1;
      ram_waddr = word_idx;
      ram_wdata = WriteData;
    end
  end

  unified_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (word_idx),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    case (region)
      REG_RAM:    ReadData = ram_rdata;
      REG_CYCLE:  ReadData = cycle_q;
      REG_TOHOST: ReadData = tohost_q;
      default:    ReadData = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_LOAD;
      load_ptr_q   <= '0;
      cycle_q      <= '0;
      tohost_q     <= '0;
      done_q       <= 1'b0;
      bad_q        <= 1'b0;
      ld_ready_q   <= 1'b1;
      core_rst_n_q <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (ld_valid) begin
            if (load_ptr_q != LAST_PTR) load_ptr_q <= load_ptr_q + 1'b1;
            if (ld_last || load_ptr_q == LAST_PTR) begin
              state_q      <= S_RUN;
              ld_ready_q   <= 1'b0;
              core_rst_n_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          cycle_q <= cycle_q + 32'd1;
          if (region == REG_NONE) bad_q <= 1'b1;
          if (MemWrite && region == REG_TOHOST) begin
            tohost_q <= WriteData;
            done_q   <= 1'b1;
            state_q  <= S_HALTED;
          end
        end
        default: ;
      endcase
    end
  end

  assign ld_ready   = ld_ready_q;
  assign core_rst_n = core_rst_n_q;
  assign done       = done_q;
  assign tohost     = tohost_q;
  assign bad_access = bad_q;

endmodule

// File: tb/tb_multicycle_mem.sv
// Scoreboard bench for multicycle_mem: stimulus queues expected values, a negedge monitor checks them.
module tb_multicycle_mem;

  localparam int          DEPTH  = 256;
  localparam logic [31:0] CYC_A  = 32'hFFFF_FF00;
  localparam logic [31:0] TOH_A  = 32'hFFFF_FF04;

  localparam int SEL_RD = 0, SEL_LDRDY = 1, SEL_CRST = 2, SEL_DONE = 3, SEL_TOH = 4, SEL_BAD = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr;
  logic        mem_write;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        core_rst_n;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        done;
  logic [31:0] tohost;
  logic        bad_access;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  multicycle_mem #(.DEPTH_WORDS(DEPTH), .CYCLE_ADDR(CYC_A), .TOHOST_ADDR(TOH_A)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .Adr        (adr),
    .MemWrite   (mem_write),
    .WriteData  (wdata),
    .ReadData   (rdata),
    .core_rst_n (core_rst_n),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .done       (done),
    .tohost     (tohost),
    .bad_access (bad_access)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_RD:    return rdata;
      SEL_LDRDY: return {31'h0, ld_ready};
      SEL_CRST:  return {31'h0, core_rst_n};
      SEL_DONE:  return {31'h0, done};
      SEL_TOH:   return tohost;
      default:   return {31'h0, bad_access};
    endcase
  endfunction

  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e   = sbq.pop_front();
      act = observe(e.sel);
      n_vec++;
      if (act !== e.val) begin
        n_err++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; adr = '0; mem_write = 1'b0; wdata = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;

    // Phase 1: reset values, 4-word boot, run, halt
    tick();
    expect_val("rst_ld_ready", SEL_LDRDY, 32'd1);
    expect_val("rst_core_rst_n", SEL_CRST, 32'd0);
    expect_val("rst_done", SEL_DONE, 32'd0);
    expect_val("rst_tohost", SEL_TOH, 32'd0);
    expect_val("rst_bad", SEL_BAD, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      ld_valid = 1'b1;
      ld_data  = 32'h11 * (i + 1);
      ld_last  = (i == 3);
      if (i == 3) expect_val("ld_ready_before_last", SEL_LDRDY, 32'd1);
    end
    tick(); // R0
    ld_valid = 1'b0; ld_last = 1'b0;
    adr = 32'h8;
    expect_val("run_ld_ready", SEL_LDRDY, 32'd0);
    expect_val("run_core_rst_n", SEL_CRST, 32'd1);
    expect_val("rd_0x8", SEL_RD, 32'h33);
    tick(); // R1
    adr = 32'h10; mem_write = 1'b1; wdata = 32'hDEAD_BEEF;
    tick(); // R2
    mem_write = 1'b0;
    expect_val("rd_after_store_0x10", SEL_RD, 32'hDEAD_BEEF);
    tick(); // R3
    adr = 32'h0;
    expect_val("rd_0x0", SEL_RD, 32'h11);
    tick(); // R4
    adr = 32'hF; // low bits ignored -> word 3
    expect_val("rd_0xF", SEL_RD, 32'h44);
    for (int i = 5; i <= 10; i++) tick();
    adr = CYC_A; mem_write = 1'b1; wdata = 32'h1234; // R10
    expect_val("cycle_at_R10", SEL_RD, 32'd10);
    tick(); // R11
    mem_write = 1'b0;
    expect_val("cycle_after_store", SEL_RD, 32'd11);
    tick(); // R12
    adr = TOH_A; mem_write = 1'b1; wdata = 32'h1;
    expect_val("tohost_rd_before", SEL_RD, 32'd0);
    tick(); // R13
    mem_write = 1'b0; adr = CYC_A;
    expect_val("halt_done", SEL_DONE, 32'd1);
    expect_val("halt_tohost", SEL_TOH, 32'd1);
    expect_val("cycle_frozen_13", SEL_RD, 32'd13);
    tick();
    adr = 32'h0; mem_write = 1'b1; wdata = 32'h55;
    tick();
    mem_write = 1'b0;
    expect_val("halted_store_ignored", SEL_RD, 32'h11);
    tick();
    adr = TOH_A;
    expect_val("tohost_rd", SEL_RD, 32'h1);
    tick();
    adr = CYC_A;
    expect_val("cycle_still_13", SEL_RD, 32'd13);
    expect_val("no_bad_yet", SEL_BAD, 32'd0);

    // Phase 2: reset clears regs not RAM; unmapped access in RUN
    tick();
    rst_n = 1'b0;
    expect_val("rst2_done", SEL_DONE, 32'd0);
    expect_val("rst2_tohost", SEL_TOH, 32'd0);
    expect_val("rst2_cycle", SEL_RD, 32'd0);
    expect_val("rst2_ld_ready", SEL_LDRDY, 32'd1);
    tick();
    rst_n = 1'b1;
    adr = 32'h8; mem_write = 1'b1; wdata = 32'h999;
    tick();
    mem_write = 1'b0;
    ld_valid = 1'b1; ld_data = 32'hAA; ld_last = 1'b1;
    tick(); // R0
    ld_valid = 1'b0; ld_last = 1'b0;
    adr = 32'h8;
    expect_val("load_store_ignored", SEL_RD, 32'h33);
    tick();
    adr = 32'h0;
    expect_val("rd_reload_0x0", SEL_RD, 32'hAA);
    tick();
    adr = 32'h10;
    expect_val("ram_kept_over_reset", SEL_RD, 32'hDEAD_BEEF);
    expect_val("bad_before", SEL_BAD, 32'd0);
    tick();
    adr = 32'h8000_0000;
    expect_val("rd_unmapped", SEL_RD, 32'd0);
    tick();
    adr = 32'h0;
    expect_val("bad_set", SEL_BAD, 32'd1);
    tick();
    rst_n = 1'b0;
    expect_val("rst3_bad", SEL_BAD, 32'd0);
    expect_val("rst3_core_rst_n", SEL_CRST, 32'd0);
    expect_val("rst3_ld_ready", SEL_LDRDY, 32'd1);

    // Phase 3: reset mid-load, then full stream without ld_last
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      ld_valid = 1'b1; ld_data = 32'hBAD0 + 32'(i); ld_last = 1'b0;
    end
    tick();
    ld_valid = 1'b0; rst_n = 1'b0;
    expect_val("midload_rst_ld_ready", SEL_LDRDY, 32'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      ld_valid = 1'b1; ld_data = 32'h1000 + 32'(i); ld_last = 1'b0;
      if (i == DEPTH - 1) expect_val("full_ld_ready_last", SEL_LDRDY, 32'd1);
    end
    tick(); // R0
    ld_valid = 1'b0;
    adr = 32'h0;
    expect_val("full_ld_ready", SEL_LDRDY, 32'd0);
    expect_val("full_core_rst_n", SEL_CRST, 32'd1);
    expect_val("full_beat0", SEL_RD, 32'h1000);
    tick();
    ld_valid = 1'b1; ld_data = 32'hFFFF;
    adr = 32'h3FC;
    expect_val("full_beat255", SEL_RD, 32'h10FF);
    tick();
    ld_valid = 1'b0;
    adr = 32'h0;
    expect_val("run_load_ignored", SEL_RD, 32'h1000);

    tick();
    tick();
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
